// File: rtl/matrix_mem_loader_if.sv
// Bundle between the matrix loader and its host / determinant-datapath partners.
// The master side is the host plus datapath; the loader owns the slave side.
interface matrix_mem_loader_if #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int RW = 16
);
  logic          load_start;
  logic [AW-1:0] load_base;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] adress;
  logic [DW-1:0] data_out;
  logic          Start;
  logic [AW-1:0] start_adress;
  logic          Done;
  logic [RW-1:0] out_put_det3;
  logic          busy;
  logic [RW-1:0] result;
  logic          result_valid;

  modport master (
    output load_start, load_base, wr_valid, wr_data, adress, Done, out_put_det3,
    input  wr_ready, data_out, Start, start_adress, busy, result, result_valid
  );

  modport slave (
    input  load_start, load_base, wr_valid, wr_data, adress, Done, out_put_det3,
    output wr_ready, data_out, Start, start_adress, busy, result, result_valid
  );
endinterface

// File: rtl/matrix_mem_loader.sv
// Memory-side partner of the 3x3 determinant unit: loads the matrix into a small store,
// kicks the datapath, serves its reads and writes the 16-bit determinant back as two bytes.
module matrix_mem_loader #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int N_ELEM = 9,
  parameter int RW     = 16
) (
  input  logic               clock,
  input  logic               reset,
  matrix_mem_loader_if.slave bus
);

  localparam int            CW     = $clog2(N_ELEM + 1);
  localparam int            DEPTH  = 2 ** AW;
  localparam logic [CW-1:0] LAST   = CW'(N_ELEM - 1);
  localparam logic [AW-1:0] OFS_LO = AW'(N_ELEM);
  localparam logic [AW-1:0] OFS_HI = AW'(N_ELEM + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_WAIT,
    S_WB_LO,
    S_WB_HI
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] result_q, result_d;
  logic          rv_q, rv_d;

  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  // Store is deliberately not reset: a reset mid-load leaves the bytes already written.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rv_d     = rv_q;
    mem_we   = 1'b0;
    mem_wa   = base_q + AW'(cnt_q);
    mem_wd   = bus.wr_data;
    unique case (state_q)
      S_IDLE: begin
        if (bus.load_start) begin
          base_d  = bus.load_base;
          cnt_d   = '0;
          rv_d    = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // wr_ready is high throughout LOAD, so a valid beat is always a transfer.
        if (bus.wr_valid) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_KICK;
          end
        end
      end
      S_KICK: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.Done) begin
          result_d = bus.out_put_det3;
          state_d  = S_WB_LO;
        end
      end
      S_WB_LO: begin
        mem_we  = 1'b1;
        mem_wa  = base_q + OFS_LO;
        mem_wd  = result_q[DW-1:0];
        state_d = S_WB_HI;
      end
      S_WB_HI: begin
        mem_we  = 1'b1;
        mem_wa  = base_q + OFS_HI;
        mem_wd  = result_q[RW-1:DW];
        rv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.wr_ready     = (state_q == S_LOAD);
  assign bus.Start        = (state_q == S_KICK);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.start_adress = base_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.data_out     = mem_q[bus.adress];

endmodule

// File: tb/tb_matrix_mem_loader.sv
// Directed-plus-random bench for matrix_mem_loader against an array model of the store
// and the expected handshake timing of each load / determinant / write-back transaction.
module tb_matrix_mem_loader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  matrix_mem_loader_if #(.AW(4), .DW(8), .RW(16)) bus ();

  matrix_mem_loader #(.AW(4), .DW(8), .N_ELEM(9), .RW(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  ref_mem [16];
  bit          known   [16];
  logic [3:0]  exp_base   = '0;
  logic [15:0] exp_result = '0;
  bit          exp_rv     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares every store location the model has a defined value for; call only in IDLE.
  task automatic check_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      if (known[a]) begin
        bus.adress = 4'(a);
        #0.1;
        chk($sformatf("%s_mem%0d", tag, a), 32'(bus.data_out), 32'(ref_mem[a]));
      end
    end
    @(negedge clock);
  endtask

  // mode 0: back-to-back, 1: valid toggles, 2: random valid. abort_at>=0 resets after that many beats.
  task automatic do_load(input logic [3:0] b, input int mode, input bit seq, input bit poke,
                         input int abort_at);
    logic [7:0] d [9];
    int acc;
    int cyc;
    bit v;
    for (int i = 0; i < 9; i++) d[i] = seq ? 8'(i + 1) : 8'($urandom);
    bus.load_start = 1'b1;
    bus.load_base  = b;
    @(negedge clock);
    bus.load_start = 1'b0;
    exp_base = b;
    exp_rv   = 1'b0;
    chk("load_busy", 32'(bus.busy), 32'd1);
    chk("load_base", 32'(bus.start_adress), 32'(b));
    chk("load_rv_clr", 32'(bus.result_valid), 32'd0);
    acc = 0;
    cyc = 0;
    while (acc < 9 && cyc < 200) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      bus.wr_valid = v;
      bus.wr_data  = d[acc];
      if (poke && cyc == 3) begin
        bus.load_start = 1'b1;
        bus.load_base  = b + 4'd5;
      end else begin
        bus.load_start = 1'b0;
      end
      chk("load_ready", 32'(bus.wr_ready), 32'd1);
      chk("load_nostart", 32'(bus.Start), 32'd0);
      @(posedge clock);
      if (v) begin
        ref_mem[(int'(b) + acc) % 16] = d[acc];
        known[(int'(b) + acc) % 16]   = 1'b1;
        acc++;
      end
      @(negedge clock);
      cyc++;
      if (abort_at >= 0 && acc == abort_at) begin
        bus.wr_valid   = 1'b0;
        bus.load_start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_result = '0;
        exp_rv     = 1'b0;
        exp_base   = '0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ready", 32'(bus.wr_ready), 32'd0);
        chk("abort_base", 32'(bus.start_adress), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        for (int k = 0; k < 4; k++) begin
          chk("abort_nostart", 32'(bus.Start), 32'd0);
          @(negedge clock);
        end
        return;
      end
    end
    bus.wr_valid   = 1'b0;
    bus.load_start = 1'b0;
    if (cyc >= 200) chk("load_timeout", 32'(acc), 32'd9);
    chk("kick_start", 32'(bus.Start), 32'd1);
    chk("kick_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge clock);
    chk("wait_start", 32'(bus.Start), 32'd0);
    chk("wait_busy", 32'(bus.busy), 32'd1);
    chk("wait_base", 32'(bus.start_adress), 32'(exp_base));
  endtask

  task automatic do_done(input logic [15:0] val, input bit poke);
    int idle_cyc;
    idle_cyc = poke ? 3 : int'($urandom_range(0, 3));
    for (int k = 0; k < idle_cyc; k++) begin
      bus.load_start = poke;
      bus.load_base  = ~exp_base;
      @(negedge clock);
      chk("wait_hold", 32'(bus.busy), 32'd1);
      chk("wait_hold_start", 32'(bus.Start), 32'd0);
    end
    bus.load_start   = 1'b0;
    bus.Done         = 1'b1;
    bus.out_put_det3 = val;
    @(negedge clock);
    bus.Done         = 1'b0;
    bus.out_put_det3 = 16'($urandom);
    exp_result = val;
    chk("wb_result", 32'(bus.result), 32'(val));
    chk("wb_lo_rv", 32'(bus.result_valid), 32'd0);
    @(negedge clock);
    chk("wb_hi_rv", 32'(bus.result_valid), 32'd0);
    chk("wb_hi_busy", 32'(bus.busy), 32'd1);
    @(negedge clock);
    ref_mem[(int'(exp_base) + 9) % 16]  = val[7:0];
    ref_mem[(int'(exp_base) + 10) % 16] = val[15:8];
    known[(int'(exp_base) + 9) % 16]    = 1'b1;
    known[(int'(exp_base) + 10) % 16]   = 1'b1;
    exp_rv = 1'b1;
    chk("done_rv", 32'(bus.result_valid), 32'd1);
    chk("done_idle", 32'(bus.busy), 32'd0);
    chk("done_result", 32'(bus.result), 32'(val));
    chk("done_base", 32'(bus.start_adress), 32'(exp_base));
  endtask

  initial begin
    for (int a = 0; a < 16; a++) known[a] = 1'b0;
    bus.load_start   = 1'b0;
    bus.load_base    = '0;
    bus.wr_valid     = 1'b0;
    bus.wr_data      = '0;
    bus.adress       = '0;
    bus.Done         = 1'b0;
    bus.out_put_det3 = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_start", 32'(bus.Start), 32'd0);
    chk("rst_rv", 32'(bus.result_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_base", 32'(bus.start_adress), 32'd0);

    // Back-to-back load at base 0, then the same-cycle read port.
    do_load(4'd0, 0, 1'b1, 1'b0, -1);
    bus.adress = 4'd3;
    #1;
    chk("read_port", 32'(bus.data_out), 32'd4);
    do_done(16'($urandom), 1'b0);
    check_mem("t1");

    // Stalling host, same data.
    do_load(4'd0, 1, 1'b1, 1'b0, -1);
    do_done(16'($urandom), 1'b0);
    check_mem("t2");

    // Wrapping base and a negative determinant.
    do_load(4'd14, 0, 1'b0, 1'b0, -1);
    do_done(16'hFFFD, 1'b0);
    bus.adress = 4'd7;
    #1;
    chk("wrap_lo", 32'(bus.data_out), 32'hFD);
    bus.adress = 4'd8;
    #1;
    chk("wrap_hi", 32'(bus.data_out), 32'hFF);
    check_mem("t3");

    // load_start while busy is ignored; Done while idle is ignored.
    do_load(4'd3, 2, 1'b0, 1'b1, -1);
    do_done(16'($urandom), 1'b1);
    bus.Done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.out_put_det3 = 16'($urandom);
      @(negedge clock);
      chk("idle_done_busy", 32'(bus.busy), 32'd0);
      chk("idle_done_result", 32'(bus.result), 32'(exp_result));
      chk("idle_done_rv", 32'(bus.result_valid), 32'(exp_rv));
    end
    bus.Done = 1'b0;
    check_mem("t4");

    // Reset mid-load, then a fresh complete load.
    do_load(4'd5, 0, 1'b0, 1'b0, 5);
    check_mem("t5a");
    do_load(4'd5, 2, 1'b0, 1'b0, -1);
    do_done(16'($urandom), 1'b0);
    check_mem("t5b");

    // Random transactions.
    for (int r = 0; r < 6; r++) begin
      do_load(4'($urandom), 2, 1'b0, 1'($urandom_range(0, 1)), -1);
      do_done(16'($urandom), 1'($urandom_range(0, 1)));
      check_mem("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
